cache_stage_reg: RTL and testbench
==================================

CACHE_STAGE_REG -- requirements
Module: cache_stage_reg

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- TAG_W, 20, tag width
- INDEX_W, 6, index width
- OFFSET_W, 6, byte offset width
- WORD_W, 32, store data width
- WAY_NUM, 4, associativity; hit/replace vector width
- SKID_EN, 1; 1 = two-entry skid buffer, 0 = single register with combinational ready
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock, rising edge
- rst, in, 1, asynchronous active-high reset
- flush, in, 1, synchronous drop of all held entries
- in_valid, in, 1, upstream entry present
- in_ready, out, 1, stage can accept
- in_wr, in, 1, store (1) / load (0)
- in_tag, in, TAG_W, request tag
- in_index, in, INDEX_W, request index
- in_offset, in, OFFSET_W, request offset
- in_store_data, in, WORD_W, store data
- in_hit_en, in, WAY_NUM, per-way hit
- in_rd_mem_en, in, 1, miss, main-memory read required
- in_replace_en, in, WAY_NUM, per-way replace select
- out_valid, out, 1, output entry present
- out_ready, in, 1, downstream accepts
- out_* (wr, tag, index, offset, store_data, hit_en, rd_mem_en, replace_en), out, widths as inputs, registered copies
- occupancy, out, 2, held entries (0..2)
- way_err, out, 1, registered; head entry has more than one hit_en bit or more than one replace_en bit set

Function
REQ-003 Input transfer SHALL occur on a cycle where in_valid && in_ready && !flush; output transfer SHALL occur on a cycle where out_valid && out_ready.
REQ-004 The entry SHALL pass through unmodified, in FIFO order, with no loss or duplication.
REQ-005 SKID_EN=1: in_ready SHALL be !skid_valid, driven from a register only (no combinational path from out_ready).
REQ-006 SKID_EN=1: minimum latency SHALL be 1 cycle (input transfer at edge N makes out_valid high after edge N).
REQ-007 SKID_EN=1: an input transfer while the main entry is valid and not being taken SHALL write the skid entry; the skid entry SHALL move to main on the next output transfer.
REQ-008 SKID_EN=1: simultaneous input and output transfers with the skid empty SHALL replace the main entry with the new one; occupancy SHALL be unchanged.
REQ-009 SKID_EN=1: full sustained throughput of 1 entry/cycle SHALL be held when out_ready is constantly 1.
REQ-010 SKID_EN=0: in_ready SHALL equal !out_valid || out_ready; skid storage SHALL not be instantiated; occupancy SHALL be at most 1.
REQ-011 Payload registers SHALL load only on a write into them; they SHALL hold value while stalled.
REQ-012 flush SHALL clear main and skid valid at the next edge, override any input transfer that cycle, and drop the input entry.
REQ-013 occupancy SHALL equal main_valid + skid_valid; it SHALL never exceed 2; in_valid while occupancy=2 SHALL be held off, never overwrite.
REQ-014 way_err SHALL be computed on the value written into the head (main) entry and registered alongside it; it SHALL be 0 whenever out_valid=0.

Reset
REQ-015 rst high SHALL asynchronously clear all valid, payload, occupancy and way_err registers to 0.
REQ-016 After reset, in_ready SHALL be 1 in both modes.
REQ-017 A rst assertion mid-transfer SHALL discard both entries; the first post-reset edge SHALL accept a new entry normally.

Structure
REQ-018 Default widths and the payload field order SHALL live in the shared cache package/define file (cache_define.v); the module SHALL take overrides via parameters.
REQ-019 One sub-module cache_stage_slot (valid + payload register with load enable) SHALL be instantiated once for main and once for skid when SKID_EN=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset, then in_valid=1, tag=0x12345, out_ready=1 -> out_valid=1 and out_tag=0x12345 next cycle; in_ready=1 throughout.
- SKID_EN=1, out_ready=0, inputs A then B -> occupancy 1 then 2; in_ready=0; out_ready=1 -> A then B; occupancy 1, then 0.
- Continuous stream 0..15, out_ready=1 -> 16 outputs in 16 consecutive cycles, in order.
- Occupancy 2, flush=1 together with in_valid=1 -> out_valid=0, occupancy=0, input entry dropped.
- hit_en=4'b0110 -> way_err=1 with that entry; replace_en=4'b0100 and hit_en=0 -> way_err=0.
- SKID_EN=0, out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally.

Source files
------------

// File: rtl/cache_stage_reg_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cache_stage_reg_pkg
// Purpose : Shared defaults and helpers for the cache pipeline stage register.
//           Holds the default field widths, the payload field order and a
//           multi-hot detector used for the way_err flag.
// Ports   : (package, none)
// Revision: 1.0 - initial release
// ============================================================================
package cache_stage_reg_pkg;

  // Default field widths; the stage module overrides these via parameters.
  localparam int TAG_W_DEF    = 20;
  localparam int INDEX_W_DEF  = 6;
  localparam int OFFSET_W_DEF = 6;
  localparam int WORD_W_DEF   = 32;
  localparam int WAY_NUM_DEF  = 4;

  // Widest way vector the multi-hot helper can inspect.
  localparam int MAX_WAY = 32;

  // Payload field order, MSB to LSB:
  //   {wr, tag, index, offset, store_data, hit_en, rd_mem_en, replace_en}
  function automatic int payload_width(input int tag_w, input int index_w,
                                       input int offset_w, input int word_w,
                                       input int way_num);
    return 2 + tag_w + index_w + offset_w + word_w + 2 * way_num;
  endfunction

  // True when more than one bit is set: clearing the lowest set bit
  // leaves something behind.
  function automatic logic multi_hot(input logic [MAX_WAY-1:0] v);
    logic [MAX_WAY-1:0] one;
    one = {{(MAX_WAY-1){1'b0}}, 1'b1};
    return (v & (v - one)) != '0;
  endfunction

endpackage : cache_stage_reg_pkg
`default_nettype wire

// File: rtl/cache_stage_reg_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cache_stage_slot
// Purpose : One storage slot of the stage: a valid bit updated every cycle
//           and a payload register that only loads when told to.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           valid_d       - next value of the valid bit
//           load, data_d  - payload load enable and data
//           valid, data   - registered valid and payload
// Revision: 1.0 - initial release
// ============================================================================
module cache_stage_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_d,
  input  logic         load,
  input  logic [W-1:0] data_d,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      valid <= valid_d;
      if (load) begin
        data <= data_d;
      end
    end
  end

endmodule : cache_stage_slot
`default_nettype wire

// File: rtl/cache_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : cache_stage_reg
// Purpose : Valid/ready pipeline register between cache lookup and the
//           refill/store stage. SKID_EN=1 gives a two-entry skid buffer with
//           a registered in_ready; SKID_EN=0 gives a single register whose
//           in_ready looks through to out_ready.
// Ports   : clk, rst, flush          - clock, async reset, sync drop-all
//           in_valid/in_ready/in_*   - upstream handshake and payload
//           out_valid/out_ready/out_*- downstream handshake and payload
//           occupancy                - number of held entries (0..2)
//           way_err                  - head entry has a multi-hot hit or
//                                      replace vector
// Revision: 1.0 - initial release
// ============================================================================
module cache_stage_reg
  import cache_stage_reg_pkg::*;
#(
  parameter int TAG_W    = TAG_W_DEF,
  parameter int INDEX_W  = INDEX_W_DEF,
  parameter int OFFSET_W = OFFSET_W_DEF,
  parameter int WORD_W   = WORD_W_DEF,
  parameter int WAY_NUM  = WAY_NUM_DEF,
  parameter bit SKID_EN  = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_wr,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic [INDEX_W-1:0]  in_index,
  input  logic [OFFSET_W-1:0] in_offset,
  input  logic [WORD_W-1:0]   in_store_data,
  input  logic [WAY_NUM-1:0]  in_hit_en,
  input  logic                in_rd_mem_en,
  input  logic [WAY_NUM-1:0]  in_replace_en,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_wr,
  output logic [TAG_W-1:0]    out_tag,
  output logic [INDEX_W-1:0]  out_index,
  output logic [OFFSET_W-1:0] out_offset,
  output logic [WORD_W-1:0]   out_store_data,
  output logic [WAY_NUM-1:0]  out_hit_en,
  output logic                out_rd_mem_en,
  output logic [WAY_NUM-1:0]  out_replace_en,
  output logic [1:0]          occupancy,
  output logic                way_err
);

  localparam int PW       = payload_width(TAG_W, INDEX_W, OFFSET_W, WORD_W, WAY_NUM);
  localparam int REP_LSB  = 0;
  localparam int RD_BIT   = WAY_NUM;
  localparam int HIT_LSB  = WAY_NUM + 1;
  localparam int DATA_LSB = 2 * WAY_NUM + 1;
  localparam int OFF_LSB  = DATA_LSB + WORD_W;
  localparam int IDX_LSB  = OFF_LSB + OFFSET_W;
  localparam int TAG_LSB  = IDX_LSB + INDEX_W;
  localparam int WR_BIT   = TAG_LSB + TAG_W;

  logic [PW-1:0] in_payload;
  logic [PW-1:0] main_src;
  logic [PW-1:0] main_data;
  logic          main_valid;
  logic          main_valid_d;
  logic          main_load;
  logic          in_xfer;
  logic          out_xfer;
  logic          err_calc;
  logic          err_q;

  assign in_payload = {in_wr, in_tag, in_index, in_offset, in_store_data,
                       in_hit_en, in_rd_mem_en, in_replace_en};

  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = main_valid && out_ready;

  // Head (main) entry.
  cache_stage_slot #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .valid_d (main_valid_d),
    .load    (main_load),
    .data_d  (main_src),
    .valid   (main_valid),
    .data    (main_data)
  );

  generate
    if (SKID_EN) begin : g_skid
      logic          skid_valid;
      logic          skid_valid_d;
      logic          skid_load;
      logic [PW-1:0] skid_data;

      cache_stage_slot #(.W(PW)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .valid_d (skid_valid_d),
        .load    (skid_load),
        .data_d  (in_payload),
        .valid   (skid_valid),
        .data    (skid_data)
      );

      // Ready depends only on the registered skid flag, breaking the
      // combinational out_ready -> in_ready path.
      assign in_ready  = !skid_valid;
      assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

      always_comb begin
        main_load    = 1'b0;
        main_valid_d = main_valid;
        main_src     = in_payload;
        skid_load    = 1'b0;
        skid_valid_d = skid_valid;
        if (flush) begin
          main_valid_d = 1'b0;
          skid_valid_d = 1'b0;
        end else if (out_xfer) begin
          if (skid_valid) begin
            // in_ready is low while the skid is full, so no input competes.
            main_load    = 1'b1;
            main_src     = skid_data;
            main_valid_d = 1'b1;
            skid_valid_d = 1'b0;
          end else if (in_xfer) begin
            main_load    = 1'b1;
            main_valid_d = 1'b1;
          end else begin
            main_valid_d = 1'b0;
          end
        end else if (in_xfer) begin
          // Skid is only ever occupied behind a valid main entry.
          if (!main_valid) begin
            main_load    = 1'b1;
            main_valid_d = 1'b1;
          end else begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
          end
        end
      end
    end else begin : g_no_skid
      assign in_ready  = !main_valid || out_ready;
      assign occupancy = {1'b0, main_valid};

      always_comb begin
        main_load    = 1'b0;
        main_valid_d = main_valid;
        main_src     = in_payload;
        if (flush) begin
          main_valid_d = 1'b0;
        end else if (in_xfer) begin
          main_load    = 1'b1;
          main_valid_d = 1'b1;
        end else if (out_xfer) begin
          main_valid_d = 1'b0;
        end
      end
    end
  endgenerate

  // way_err is evaluated on whatever is being written into the head.
  always_comb begin
    logic [MAX_WAY-1:0] hit_ext;
    logic [MAX_WAY-1:0] rep_ext;
    hit_ext = '0;
    rep_ext = '0;
    hit_ext[WAY_NUM-1:0] = main_src[HIT_LSB +: WAY_NUM];
    rep_ext[WAY_NUM-1:0] = main_src[REP_LSB +: WAY_NUM];
    err_calc = multi_hot(hit_ext) || multi_hot(rep_ext);
  end

  // Cleared whenever the head goes empty so it never outlives its entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!main_valid_d) begin
      err_q <= 1'b0;
    end else if (main_load) begin
      err_q <= err_calc;
    end
  end

  assign way_err        = err_q;
  assign out_valid      = main_valid;
  assign out_wr         = main_data[WR_BIT];
  assign out_tag        = main_data[TAG_LSB +: TAG_W];
  assign out_index      = main_data[IDX_LSB +: INDEX_W];
  assign out_offset     = main_data[OFF_LSB +: OFFSET_W];
  assign out_store_data = main_data[DATA_LSB +: WORD_W];
  assign out_hit_en     = main_data[HIT_LSB +: WAY_NUM];
  assign out_rd_mem_en  = main_data[RD_BIT];
  assign out_replace_en = main_data[REP_LSB +: WAY_NUM];

endmodule : cache_stage_reg
`default_nettype wire

// File: tb/tb_cache_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_cache_stage_reg
// Purpose : Self-checking bench driving a skid-buffer instance and a
//           single-register instance with the same stimulus, each compared
//           against a queue-based reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_stage_reg;

  typedef struct packed {
    logic        wr;
    logic [19:0] tag;
    logic [5:0]  index;
    logic [5:0]  offset;
    logic [31:0] data;
    logic [3:0]  hit;
    logic        rd;
    logic [3:0]  rep;
  } payload_t;

  logic     clk = 1'b0;
  logic     rst;
  logic     flush;
  logic     in_valid;
  logic     out_ready;
  payload_t in_p;

  logic rdy1, ov1, err1, rdy0, ov0, err0;
  logic [1:0] occ1, occ0;
  logic        o1_wr, o0_wr, o1_rd, o0_rd;
  logic [19:0] o1_tag, o0_tag;
  logic [5:0]  o1_idx, o0_idx, o1_off, o0_off;
  logic [31:0] o1_dat, o0_dat;
  logic [3:0]  o1_hit, o0_hit, o1_rep, o0_rep;
  payload_t    pay1, pay0;

  assign pay1 = {o1_wr, o1_tag, o1_idx, o1_off, o1_dat, o1_hit, o1_rd, o1_rep};
  assign pay0 = {o0_wr, o0_tag, o0_idx, o0_off, o0_dat, o0_hit, o0_rd, o0_rep};

  always #5 clk = ~clk;

  cache_stage_reg #(.SKID_EN(1'b1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_wr(in_p.wr), .in_tag(in_p.tag), .in_index(in_p.index),
    .in_offset(in_p.offset), .in_store_data(in_p.data), .in_hit_en(in_p.hit),
    .in_rd_mem_en(in_p.rd), .in_replace_en(in_p.rep),
    .out_valid(ov1), .out_ready(out_ready),
    .out_wr(o1_wr), .out_tag(o1_tag), .out_index(o1_idx), .out_offset(o1_off),
    .out_store_data(o1_dat), .out_hit_en(o1_hit), .out_rd_mem_en(o1_rd),
    .out_replace_en(o1_rep), .occupancy(occ1), .way_err(err1)
  );

  cache_stage_reg #(.SKID_EN(1'b0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_wr(in_p.wr), .in_tag(in_p.tag), .in_index(in_p.index),
    .in_offset(in_p.offset), .in_store_data(in_p.data), .in_hit_en(in_p.hit),
    .in_rd_mem_en(in_p.rd), .in_replace_en(in_p.rep),
    .out_valid(ov0), .out_ready(out_ready),
    .out_wr(o0_wr), .out_tag(o0_tag), .out_index(o0_idx), .out_offset(o0_off),
    .out_store_data(o0_dat), .out_hit_en(o0_hit), .out_rd_mem_en(o0_rd),
    .out_replace_en(o0_rep), .occupancy(occ0), .way_err(err0)
  );

  // Reference model: the ordered list of entries each stage holds.
  payload_t q1[$];
  payload_t q0[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input payload_t p);
    return ($countones(p.hit) > 1) || ($countones(p.rep) > 1);
  endfunction

  function automatic payload_t rnd_p();
    payload_t p;
    p.wr     = 1'($urandom_range(0, 1));
    p.tag    = 20'($urandom);
    p.index  = 6'($urandom);
    p.offset = 6'($urandom);
    p.data   = $urandom;
    p.hit    = 4'($urandom_range(0, 15));
    p.rd     = 1'($urandom_range(0, 1));
    p.rep    = 4'($urandom_range(0, 15));
    return p;
  endfunction

  task automatic chk_model(input string nm, input bit skid, input int sz,
                           input payload_t head, input logic rdy, input logic vld,
                           input logic [1:0] occ, input logic err, input payload_t pay);
    logic erdy;
    erdy = skid ? (sz < 2) : (sz == 0 || out_ready);
    chk({nm, "_in_ready"}, 128'(rdy), 128'(erdy));
    chk({nm, "_out_valid"}, 128'(vld), 128'(sz > 0));
    chk({nm, "_occupancy"}, 128'(occ), 128'(sz));
    chk({nm, "_way_err"}, 128'(err), 128'((sz > 0) ? exp_err(head) : 1'b0));
    if (sz > 0) chk({nm, "_payload"}, 128'(pay), 128'(head));
  endtask

  // One clock cycle: drive at the falling edge, check, advance the model.
  task automatic step(input logic v, input payload_t p, input logic ordy, input logic fl);
    payload_t h1, h0;
    bit acc1, acc0;
    in_valid = v; in_p = p; out_ready = ordy; flush = fl;
    #1;
    h1 = '0; h0 = '0;
    if (q1.size() > 0) h1 = q1[0];
    if (q0.size() > 0) h0 = q0[0];
    chk_model("skid", 1'b1, q1.size(), h1, rdy1, ov1, occ1, err1, pay1);
    chk_model("single", 1'b0, q0.size(), h0, rdy0, ov0, occ0, err0, pay0);
    acc1 = v && (q1.size() < 2) && !fl;
    acc0 = v && (q0.size() == 0 || ordy) && !fl;
    if (fl) begin
      q1.delete();
      q0.delete();
    end else begin
      if (q1.size() > 0 && ordy) void'(q1.pop_front());
      if (q0.size() > 0 && ordy) void'(q0.pop_front());
      if (acc1) q1.push_back(p);
      if (acc0) q0.push_back(p);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    payload_t a, b, c, p;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_p = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready_skid", 128'(rdy1), 128'(1));
    chk("rst_in_ready_single", 128'(rdy0), 128'(1));
    chk("rst_occ_skid", 128'(occ1), 128'(0));
    chk("rst_out_valid_skid", 128'(ov1), 128'(0));
    chk("rst_payload_skid", 128'(pay1), 128'(0));
    chk("rst_way_err_single", 128'(err0), 128'(0));
    rst = 1'b0;

    // First entry after reset appears one cycle later.
    p = '0; p.tag = 20'h12345;
    step(1'b1, p, 1'b1, 1'b0);
    chk("d1_out_valid", 128'(ov1), 128'(1));
    chk("d1_out_tag", 128'(o1_tag), 128'h12345);
    chk("d1_out_tag_single", 128'(o0_tag), 128'h12345);
    step(1'b0, '0, 1'b1, 1'b0);

    // Fill the skid buffer, then drain it in order.
    a = rnd_p(); b = rnd_p();
    step(1'b1, a, 1'b0, 1'b0);
    chk("d2_occ_a", 128'(occ1), 128'(1));
    step(1'b1, b, 1'b0, 1'b0);
    chk("d2_occ_ab", 128'(occ1), 128'(2));
    chk("d2_in_ready_full", 128'(rdy1), 128'(0));
    chk("d2_head_a", 128'(pay1), 128'(a));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("d2_occ_b", 128'(occ1), 128'(1));
    chk("d2_head_b", 128'(pay1), 128'(b));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("d2_occ_empty", 128'(occ1), 128'(0));

    // Back-to-back stream at full rate.
    for (int i = 0; i < 16; i++) begin
      p = rnd_p(); p.tag = 20'(i);
      step(1'b1, p, 1'b1, 1'b0);
    end
    chk("d3_last_tag", 128'(o1_tag), 128'(15));
    step(1'b0, '0, 1'b1, 1'b0);

    // Flush while full drops held entries and the concurrent input.
    a = rnd_p(); b = rnd_p(); c = rnd_p();
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    step(1'b1, c, 1'b0, 1'b1);
    chk("d4_out_valid", 128'(ov1), 128'(0));
    chk("d4_occ", 128'(occ1), 128'(0));
    chk("d4_occ_single", 128'(occ0), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);

    // way_err follows the head entry.
    p = rnd_p(); p.hit = 4'b0110; p.rep = 4'b0000;
    step(1'b1, p, 1'b1, 1'b0);
    chk("d5_way_err_multi", 128'(err1), 128'(1));
    p = rnd_p(); p.hit = 4'b0000; p.rep = 4'b0100;
    step(1'b1, p, 1'b1, 1'b0);
    chk("d5_way_err_onehot", 128'(err1), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);

    // Single-register mode: in_ready tracks out_ready combinationally.
    a = rnd_p();
    step(1'b1, a, 1'b0, 1'b0);
    in_valid = 1'b1; out_ready = 1'b0;
    #1 chk("d6_in_ready_stall", 128'(rdy0), 128'(0));
    out_ready = 1'b1;
    #1 chk("d6_in_ready_pass", 128'(rdy0), 128'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of traffic.
    a = rnd_p(); b = rnd_p(); c = rnd_p();
    step(1'b1, a, 1'b0, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("d7_rst_valid", 128'(ov1), 128'(0));
    chk("d7_rst_occ", 128'(occ1), 128'(0));
    chk("d7_rst_valid_single", 128'(ov0), 128'(0));
    q1.delete(); q0.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, c, 1'b1, 1'b0);
    chk("d7_post_rst_tag", 128'(o1_tag), 128'(c.tag));

    // Random traffic against the model.
    repeat (400) begin
      step($urandom_range(0, 9) < 7, rnd_p(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cache_stage_reg
`default_nettype wire
